// File: rtl/mem_req_ctrl_pkg.sv
// mem_req_ctrl_pkg: shared widths, FSM state and transaction type for mem_req_ctrl
package mem_req_ctrl_pkg;
    localparam int ADDR_LEN  = 8;
    localparam int WORD_LEN  = 8;
    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic                we;
        logic [ADDR_LEN-1:0] addr;
        logic [WORD_LEN-1:0] wdata;
        logic                port;
    } txn_t;
endpackage

// File: rtl/mem_req_ctrl_if.sv
// mem_req_ctrl_if: one requester port of mem_req_ctrl
//   request : req_valid, req_ready, req_we, req_addr, req_wdata
//   response: rsp_valid (one-cycle pulse, no backpressure), rsp_rdata
//   master = requester side, slave = controller side
interface mem_req_ctrl_if;
    import mem_req_ctrl_pkg::*;
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [ADDR_LEN-1:0] req_addr;
    logic [WORD_LEN-1:0] req_wdata;
    logic                rsp_valid;
    logic [WORD_LEN-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_req_ctrl_arb.sv
// mem_req_arb: 2-way arbiter for mem_req_ctrl
//   clk, rst : clock, synchronous active-high reset
//   valid    : per-port request valids
//   accept   : a grant was taken this cycle (advances the round-robin pointer)
//   grant    : one-hot grant, zero when nothing is valid
//   MEM_REQ_CTRL_RR_EN defined: round-robin; undefined: fixed priority to port 0
module mem_req_arb
    import mem_req_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] valid,
    input  logic                 accept,
    output logic [NUM_PORTS-1:0] grant
);
`ifdef MEM_REQ_CTRL_RR_EN
    // ptr names the port that wins the next contention
    logic ptr;

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 1'b0;
        else if (accept)
            ptr <= ~grant[1];
    end

    always_comb begin
        grant[0] = valid[0] & (~valid[1] | ~ptr);
        grant[1] = valid[1] & (~valid[0] | ptr);
    end
`else
    // fixed priority needs no state; clk/rst/accept are intentionally unused here
    logic unused;
    assign unused = ^{clk, rst, accept};

    always_comb grant = valid[0] ? 2'b01 : {valid[1], 1'b0};
`endif
endmodule

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: two-port request controller in front of the single-port MEMORY block
//   clk, rst     : clock, synchronous active-high reset
//   p0, p1       : requester ports (p0 = fetch, p1 = load/store), slave side
//   mem_addr     : to MEMORY.addr, holds the last transaction's address
//   mem_r_en     : to MEMORY.r_en, high only in the ACCESS cycle of a read
//   mem_w_en     : to MEMORY.w_en, high only in the ACCESS cycle of a write
//   mem_data_in  : to MEMORY.data_in, holds the last transaction's write data
//   mem_data_out : from MEMORY.data_out, sampled at the end of a read ACCESS
//   Optional macro MEM_REQ_CTRL_RR_EN selects round-robin arbitration.
module mem_req_ctrl
    import mem_req_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    mem_req_ctrl_if.slave       p0,
    mem_req_ctrl_if.slave       p1,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic                mem_r_en,
    output logic                mem_w_en,
    output logic [WORD_LEN-1:0] mem_data_in,
    input  logic [WORD_LEN-1:0] mem_data_out
);
    state_t               state;
    state_t               state_nx;
    txn_t                 txn;
    logic [WORD_LEN-1:0]  rdata;
    logic [NUM_PORTS-1:0] grant;
    logic                 open;
    logic                 accept;

    mem_req_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  ({p1.req_valid, p0.req_valid}),
        .accept (accept),
        .grant  (grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            txn   <= '0;
            rdata <= '0;
        end else begin
            state <= state_nx;
            if (accept)
                txn <= grant[1] ? {p1.req_we, p1.req_addr, p1.req_wdata, 1'b1}
                                : {p0.req_we, p0.req_addr, p0.req_wdata, 1'b0};
            if (state == ACCESS && !txn.we)
                rdata <= mem_data_out;
        end
    end

    // Memory pins come straight from the transaction register, so they only
    // change on an accept edge; the strobes are decoded from ACCESS alone.
    // Ready is blocked during reset so a request is never taken while resetting.
    always_comb begin
        open         = !rst && state != ACCESS;
        accept       = open && |grant;
        state_nx     = accept ? ACCESS : (state == ACCESS ? RESP : IDLE);
        p0.req_ready = open && grant[0];
        p1.req_ready = open && grant[1];
        p0.rsp_valid = state == RESP && !txn.port;
        p1.rsp_valid = state == RESP && txn.port;
        p0.rsp_rdata = rdata;
        p1.rsp_rdata = rdata;
        mem_addr     = txn.addr;
        mem_data_in  = txn.wdata;
        mem_r_en     = state == ACCESS && !txn.we;
        mem_w_en     = state == ACCESS && txn.we;
    end
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: self-checking bench for mem_req_ctrl against a cycle-level reference model
module tb_mem_req_ctrl;
    import mem_req_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_req_ctrl_if p0 ();
    mem_req_ctrl_if p1 ();

    logic [7:0] mem_addr, mem_data_in, mem_data_out;
    logic       mem_r_en, mem_w_en;

    mem_req_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .p0           (p0),
        .p1           (p1),
        .mem_addr     (mem_addr),
        .mem_r_en     (mem_r_en),
        .mem_w_en     (mem_w_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // MEMORY stand-in: combinational read, write on the rising edge
    logic [7:0] mem [256] = '{default: 8'h00};
    always @(posedge clk) if (mem_w_en) mem[mem_addr] <= mem_data_in;
    assign mem_data_out = mem[mem_addr];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a transaction accepted in cycle c strobes in c+1 and
    // responds in c+2; ref_mem is updated in acceptance order.
    bit         mon_en = 0;
    int         cyc = 0;
    bit         sv [4], swe [4], rv [4], rp [4], rwe [4];
    logic [7:0] sa [4], sd [4], rd [4];
    logic [7:0] ref_mem [256] = '{default: 8'h00};
    logic [7:0] last_a = 0, last_d = 0;
    bit         pref = 0;
    bit         acc0 = 0, acc1 = 0;
    int         wen_cnt = 0, rsp0_cnt = 0, rsp1_cyc = 0;
    logic [7:0] last_rsp0 = 0, last_rsp1 = 0;

    always @(negedge clk) if (mon_en) begin
        int k, k1, k2;
        bit e0, e1, we;
        logic [7:0] a, d;
        k  = cyc % 4;
        k1 = (cyc + 1) % 4;
        k2 = (cyc + 2) % 4;
        e0 = !rst && !sv[k] && p0.req_valid && (!p1.req_valid || !pref);
        e1 = !rst && !sv[k] && p1.req_valid && (!p0.req_valid || pref);
        chk("ready0", p0.req_ready, e0);
        chk("ready1", p1.req_ready, e1);
        if (sv[k]) begin
            last_a = sa[k];
            last_d = sd[k];
        end
        chk("w_en", mem_w_en, sv[k] && swe[k]);
        chk("r_en", mem_r_en, sv[k] && !swe[k]);
        chk("mem_addr", mem_addr, last_a);
        chk("mem_data_in", mem_data_in, last_d);
        chk("rsp_valid0", p0.rsp_valid, rv[k] && !rp[k]);
        chk("rsp_valid1", p1.rsp_valid, rv[k] && rp[k]);
        if (rv[k] && !rwe[k]) begin
            if (rp[k]) begin
                chk("rsp_rdata1", p1.rsp_rdata, rd[k]);
                last_rsp1 = p1.rsp_rdata;
            end else begin
                chk("rsp_rdata0", p0.rsp_rdata, rd[k]);
                last_rsp0 = p0.rsp_rdata;
            end
        end
        if (mem_w_en) wen_cnt++;
        if (p0.rsp_valid) rsp0_cnt++;
        if (p1.rsp_valid) rsp1_cyc = cyc;
        sv[k] = 0;
        rv[k] = 0;
        acc0 = e0;
        acc1 = e1;
        if (e0 || e1) begin
            we = e1 ? p1.req_we : p0.req_we;
            a  = e1 ? p1.req_addr : p0.req_addr;
            d  = e1 ? p1.req_wdata : p0.req_wdata;
            sv[k1] = 1; swe[k1] = we; sa[k1] = a; sd[k1] = d;
            rv[k2] = 1; rp[k2] = e1; rwe[k2] = we;
            if (we) ref_mem[a] = d;
            else rd[k2] = ref_mem[a];
`ifdef MEM_REQ_CTRL_RR_EN
            pref = e0;
`endif
        end
        if (rst) begin
            sv[k1] = 0; rv[k1] = 0; rv[k2] = 0;
            last_a = 0; last_d = 0; pref = 0;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int port, input bit v, input bit we, input logic [7:0] a, input logic [7:0] d);
        if (port == 1) begin
            p1.req_valid = v; p1.req_we = we; p1.req_addr = a; p1.req_wdata = d;
        end else begin
            p0.req_valid = v; p0.req_we = we; p0.req_addr = a; p0.req_wdata = d;
        end
    endtask

    task automatic rnd_req(input int port);
        logic [7:0] a;
        a = ($urandom_range(0, 8) == 8) ? 8'hFF : 8'($urandom_range(0, 7));
        set_req(port, 1, 1'($urandom_range(0, 1)), a, 8'($urandom));
    endtask

    // wait (bounded) for the given port's request to be accepted
    task automatic wait_acc(input int port, input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            ok = (port == 1) ? acc1 : acc0;
        end
        chk(tag, ok, 1);
    endtask

    initial begin
        int gl[$];
        int w0, a1, a2, n;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);

        // reset held 3 cycles with both ports requesting
        rnd_req(0);
        rnd_req(1);
        rst = 1;
        step();
        mon_en = 1;
        step();
        step();
        rst = 0;

        // both ports valid continuously for six accepts
        for (int i = 0; i < 40 && gl.size() < 6; i++) begin
            step();
            if (acc0) begin gl.push_back(0); rnd_req(0); end
            if (acc1) begin gl.push_back(1); rnd_req(1); end
        end
        chk("grant_count", gl.size(), 6);
        for (int i = 0; i < gl.size(); i++)
`ifdef MEM_REQ_CTRL_RR_EN
            chk($sformatf("grant%0d", i), gl[i], i % 2);
`else
            chk($sformatf("grant%0d", i), gl[i], 0);
`endif
        p0.req_valid = 0;
        p1.req_valid = 0;
        repeat (3) step();

        // port 0 write 0x3C @0x10, then read it back
        w0 = wen_cnt;
        set_req(0, 1, 1, 8'h10, 8'h3C);
        wait_acc(0, "acc_w10");
        set_req(0, 1, 0, 8'h10, 8'h00);
        wait_acc(0, "acc_r10");
        p0.req_valid = 0;
        step();
        step();
        chk("wen_once", wen_cnt - w0, 1);
        chk("rd_10", last_rsp0, 8'h3C);

        // preload 0xFF/0x00 through port 1, then back-to-back reads
        set_req(1, 1, 1, 8'hFF, 8'hA5);
        wait_acc(1, "pl_ff");
        set_req(1, 1, 1, 8'h00, 8'h5A);
        wait_acc(1, "pl_00");
        p1.req_valid = 0;
        step();
        set_req(1, 1, 0, 8'hFF, 8'h00);
        wait_acc(1, "acc_rff");
        a1 = cyc;
        set_req(1, 1, 0, 8'h00, 8'h00);
        wait_acc(1, "acc_r00");
        a2 = cyc;
        p1.req_valid = 0;
        chk("b2b_gap", a2 - a1, 2);
        chk("acc_with_rsp", rsp1_cyc, a2 - 1);
        chk("rd_ff", last_rsp1, 8'hA5);
        step();
        step();
        chk("rd_00", last_rsp1, 8'h5A);

        // reset pulsed in the ACCESS cycle of a port 0 read
        set_req(0, 1, 0, 8'h00, 8'h00);
        wait_acc(0, "acc_dropped");
        p0.req_valid = 0;
        rst = 1;
        step();
        rst = 0;
        n = rsp0_cnt;
        step();
        step();
        chk("no_rsp_after_rst", rsp0_cnt - n, 0);
        set_req(0, 1, 0, 8'hFF, 8'h00);
        wait_acc(0, "acc_after_rst");
        p0.req_valid = 0;
        step();
        step();
        chk("rsp_after_rst", rsp0_cnt - n, 1);
        chk("rd_after_rst", last_rsp0, 8'hA5);

        // port 1 write while port 0 is held waiting
        set_req(1, 1, 1, 8'h22, 8'h77);
        wait_acc(1, "acc_w22");
        p1.req_valid = 0;
        set_req(0, 1, 0, 8'h22, 8'h00);
        step();
        chk("p0_stalled", acc0, 0);
        wait_acc(0, "acc_r22");
        p0.req_valid = 0;
        step();
        step();
        chk("rd_22", last_rsp0, 8'h77);

        // randomized traffic with occasional reset pulses
        for (int i = 0; i < 400; i++) begin
            step();
            rst = ($urandom_range(0, 40) == 0);
            if (acc0 || !p0.req_valid) begin
                if ($urandom_range(0, 2) == 0) p0.req_valid = 0;
                else rnd_req(0);
            end
            if (acc1 || !p1.req_valid) begin
                if ($urandom_range(0, 2) == 0) p1.req_valid = 0;
                else rnd_req(1);
            end
        end
        rst = 0;
        p0.req_valid = 0;
        p1.req_valid = 0;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Two-port request controller sitting directly upstream of the single-port `MEMORY` block. It arbitrates between a fetch requester (port 0) and a load/store requester (port 1), sequences exactly one memory strobe per transaction onto `MEMORY`'s `addr`/`r_en`/`w_en`/`data_in`, registers `data_out` and returns a one-cycle response to the winning requester. It hides `MEMORY`'s level-sensitive control from requesters: strobes and address are only ever active in a single, state-decoded cycle.

## Interface
- `ADDR_LEN`, 8, address width, matches `MEMORY`
- `WORD_LEN`, 8, data width, matches `MEMORY`

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset: synchronous, active-high
- `req_valid_i` (i=0,1)  in  1  request present
- `req_ready_i`  out  1  request accepted this cycle when `req_valid_i` is also high
- `req_we_i`  in  1  1 = write, 0 = read
- `req_addr_i`  in  `ADDR_LEN`  address
- `req_wdata_i`  in  `WORD_LEN`  write data
- `rsp_valid_i`  out  1  one-cycle completion pulse; no backpressure
- `rsp_rdata_i`  out  `WORD_LEN`  read data, valid with `rsp_valid_i` on reads
- `mem_addr`  out  `ADDR_LEN`  to `MEMORY.addr`
- `mem_r_en`  out  1  to `MEMORY.r_en`
- `mem_w_en`  out  1  to `MEMORY.w_en`
- `mem_data_in`  out  `WORD_LEN`  to `MEMORY.data_in`
- `mem_data_out`  in  `WORD_LEN`  from `MEMORY.data_out`

## Operation
- FSM states: `IDLE`, `ACCESS`, `RESP`.
- `IDLE`: if any `req_valid_i`, arbiter picks grant `g`; `req_ready_g`=1 (other port 0); on the edge, latch `we`, `addr`, `wdata`, `g` into the transaction register → `ACCESS`. No valid → stay.
- `ACCESS`: `mem_addr`=latched addr; `mem_r_en`=!we, `mem_w_en`=we, each for exactly this one cycle; `mem_data_in`=latched wdata. On reads, capture `mem_data_out` into the rdata register at the closing edge → `RESP`.
- `RESP`: `rsp_valid_g`=1 for one cycle; `rsp_rdata_g`=rdata register (writes: rdata register unchanged, value don't-care). Accepts a new request exactly as in `IDLE` (→ `ACCESS`), else → `IDLE`.
- `req_ready_i` is high only if `req_valid_i` is high, port i is granted, and state is `IDLE` or `RESP`. Ready may depend on valid; valid must not depend on ready.
- Requester holds `req_*` stable while valid and not ready.
- Outside `ACCESS`: `mem_r_en`=`mem_w_en`=0, `mem_addr` and `mem_data_in` hold the last transaction's values (no toggling).
- Write-then-read to the same address from either port returns the written data (strict one-at-a-time ordering).

## Timing
- Reset values: state `IDLE`, all `req_ready_i`/`rsp_valid_i`/`mem_r_en`/`mem_w_en` 0, `mem_addr`/`mem_data_in`/`rsp_rdata_i` 0, arbiter pointer = port 0.
- Accept at edge N → `ACCESS` in cycle N+1 → `rsp_valid` in cycle N+2. Latency 2 cycles. Peak throughput one transaction per 2 cycles.
- Reset in `ACCESS`: that cycle's strobe still drives (state-decoded); next cycle all outputs at reset values, no response ever issued, transaction dropped.
- Reset in `RESP`: `rsp_valid` of that cycle is still seen; any simultaneous accept is discarded.
- Address 0 and `2^ADDR_LEN-1` are not special; no wrap logic.

## Configuration
- `MEM_REQ_CTRL_RR_EN` defined: round-robin. When both ports are valid, grant the port not granted last; the pointer updates only on accept.
- Undefined: fixed priority. Port 0 always wins on contention, and port 1 can starve. The pointer register is not built.

## Structure
- Package `mem_req_ctrl_pkg`: FSM state enum, default `ADDR_LEN`/`WORD_LEN`, `NUM_PORTS`=2, transaction struct (`we`, `addr`, `wdata`, `port`).
- One sub-module, `mem_req_arb`: 2-way arbiter (valids in, one-hot grant out, pointer update on accept strobe). Contains the `MEM_REQ_CTRL_RR_EN` logic.

## Test plan
- Reset held 3 cycles with both valids high → all outputs 0, no ready, no strobe; first accept in the first cycle after `rst` falls.
- Port 0 write 0x3C @0x10, then read @0x10 → exactly one `mem_w_en` cycle with addr 0x10/data 0x3C; read gives `rsp_valid_0` 2 cycles after accept with `rsp_rdata_0`=0x3C.
- Both ports valid continuously, 6 transactions → RR: grants 0,1,0,1,0,1; without macro: 0 for all six, `req_ready_1` never high.
- Port 1 back-to-back reads @0xFF, 0x00 (preloaded 0xA5, 0x5A) → accepts 2 cycles apart, responses 0xA5 then 0x5A, second accept coincides with first `rsp_valid_1`.
- `rst` pulsed in the `ACCESS` cycle of a port 0 read → no `rsp_valid_0`, state `IDLE`, next request completes normally.
- Port 1 write during port 0 stall (valid held, not granted) → port 0 request fields unchanged until accepted, then completes with correct data.
